// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared framebuffer definitions for the rectangle-fill writer, the VGA
// scan-out block and the video-memory wrapper.
//   FB_COLS / FB_ROWS / FB_ADDR_W : framebuffer geometry (256 x 16 bytes)
//   fb_pixel_t                    : one framebuffer byte
//   fb_state_t + ST_*             : rectangle-fill FSM encoding
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_COLS   = 256;
  localparam int FB_ROWS   = 16;
  localparam int FB_ADDR_W = 12;
  localparam int FB_DATA_W = 8;

  typedef logic [FB_DATA_W-1:0] fb_pixel_t;

  typedef logic [1:0] fb_state_t;
  localparam fb_state_t ST_IDLE = 2'd0;
  localparam fb_state_t ST_FILL = 2'd1;
  localparam fb_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/fb_rect_counter.sv
// -----------------------------------------------------------------------------
// fb_rect_counter
// Row-major x/y walker over a clipped rectangle.
//   clock, reset : system clock, synchronous active-high reset
//   load         : start a new rectangle at (x0, y0) of size w_eff x h_eff
//                  (both nonzero, already clipped to the framebuffer)
//   enable       : the current pixel was written this cycle; step to the next
//   x, y         : current pixel position (registered)
//   last         : current pixel is the bottom-right corner of the rectangle
// The position does not move past the last pixel, so the address seen by the
// memory keeps the final written location after the fill.
// -----------------------------------------------------------------------------
module fb_rect_counter
  import fb_pkg::*;
#(
  parameter int X_W = 8,
  parameter int Y_W = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           enable,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W:0]   w_eff,
  input  logic [Y_W:0]   h_eff,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] x_start;
  logic [X_W-1:0] x_end;
  logic [Y_W-1:0] y_end;
  logic [X_W:0]   x_end_full;
  logic [Y_W:0]   y_end_full;

  // Clipping guarantees x0 + w_eff <= 2**X_W, so the inclusive end fits X_W bits.
  assign x_end_full = {1'b0, x0} + w_eff - (X_W+1)'(1);
  assign y_end_full = {1'b0, y0} + h_eff - (Y_W+1)'(1);

  assign last = (x == x_end) && (y == y_end);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      x       <= '0;
      y       <= '0;
      x_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
    end else if (load) begin
      x       <= x0;
      y       <= y0;
      x_start <= x0;
      x_end   <= x_end_full[X_W-1:0];
      y_end   <= y_end_full[Y_W-1:0];
    end else if (enable && !last) begin
      if (x == x_end) begin
        x <= x_start;
        y <= y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/fb_rect_fill.sv
// -----------------------------------------------------------------------------
// fb_rect_fill
// Rectangle-fill writer for the VGA framebuffer. Accepts one command over a
// valid/ready handshake, clips it to the 256 x 16 framebuffer and writes the
// fill colour one pixel per clock in row-major order.
//   clock, reset       : system clock, synchronous active-high reset
//   cmd_valid/ready    : command handshake (ready only while idle)
//   cmd_x0, cmd_y0     : start column / row
//   cmd_w, cmd_h       : width 0..256, height 0..16
//   cmd_color          : fill value
//   blank              : scan-out visible-pixel flag (used only when gated)
//   wr_en/addr/data    : video-memory write port, addr = {y, x}
//   busy               : command in progress
//   done               : one-cycle pulse after the last write
// Build option FB_BLANK_GATE_EN: suppress writes while blank is high so the
// writer never contends with scan-out; the fill resumes at the same pixel.
// -----------------------------------------------------------------------------
module fb_rect_fill
  import fb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int X_W    = 8,
  parameter int Y_W    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [X_W-1:0]     cmd_x0,
  input  logic [Y_W-1:0]     cmd_y0,
  input  logic [X_W:0]       cmd_w,
  input  logic [Y_W:0]       cmd_h,
  input  logic [DATA_W-1:0]  cmd_color,
  input  logic               blank,
  output logic               wr_en,
  output logic [X_W+Y_W-1:0] wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done
);

  fb_state_t      state;
  fb_state_t      next_state;
  logic           accept;
  logic           load;
  logic           gate;
  logic           last;
  logic [X_W:0]   x_room;
  logic [Y_W:0]   y_room;
  logic [X_W:0]   w_eff;
  logic [Y_W:0]   h_eff;
  logic [X_W-1:0] cnt_x;
  logic [Y_W-1:0] cnt_y;

  // Room left to the right/bottom edge; one extra bit so 256 and 16 fit.
  assign x_room = (X_W+1)'(1 << X_W) - {1'b0, cmd_x0};
  assign y_room = (Y_W+1)'(1 << Y_W) - {1'b0, cmd_y0};
  assign w_eff  = (cmd_w < x_room) ? cmd_w : x_room;
  assign h_eff  = (cmd_h < y_room) ? cmd_h : y_room;

  assign accept = (state == ST_IDLE) && cmd_valid && cmd_ready;

  // blank is sampled at the edge that launches a write, which keeps wr_en a
  // plain register while still skipping every blanked slot.
`ifdef FB_BLANK_GATE_EN
  assign gate = blank;
`else
  logic unused_blank;
  assign unused_blank = blank;
  assign gate         = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (w_eff == '0 || h_eff == '0) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_FILL;
            load       = 1'b1;
          end
        end
      end
      ST_FILL: if (wr_en && last) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state
  // they describe. A write in flight (wr_en) is what steps the counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
    end else begin
      state     <= next_state;
      cmd_ready <= (next_state == ST_IDLE);
      busy      <= (next_state != ST_IDLE);
      done      <= (next_state == ST_DONE);
      wr_en     <= (next_state == ST_FILL) && !gate;
      if (load) wr_data <= cmd_color;
    end
  end

  fb_rect_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .enable (wr_en),
    .x0     (cmd_x0),
    .y0     (cmd_y0),
    .w_eff  (w_eff),
    .h_eff  (h_eff),
    .x      (cnt_x),
    .y      (cnt_y),
    .last   (last)
  );

  assign wr_addr = {cnt_y, cnt_x};

endmodule

// File: tb/tb_fb_rect_fill.sv
// -----------------------------------------------------------------------------
// tb_fb_rect_fill
// Self-checking bench for fb_rect_fill. A reference model expands each accepted
// command into the list of (cycle, address, data) writes plus the done cycle;
// one compare process checks the write port and done against it every cycle.
// Literal expectations from hand calculation pin the model.
// Cycle numbering: cyc counts rising edges; "cycle e" is the interval after
// edge e. A command accepted on edge N writes first in cycle N.
// -----------------------------------------------------------------------------
module tb_fb_rect_fill;
  import fb_pkg::*;

  localparam int DATA_W = 8;
  localparam int X_W    = 8;
  localparam int Y_W    = 4;

`ifdef FB_BLANK_GATE_EN
  localparam bit GATE_EN = 1'b1;
`else
  localparam bit GATE_EN = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [X_W-1:0]     cmd_x0 = '0;
  logic [Y_W-1:0]     cmd_y0 = '0;
  logic [X_W:0]       cmd_w = '0;
  logic [Y_W:0]       cmd_h = '0;
  logic [DATA_W-1:0]  cmd_color = '0;
  logic               blank = 1'b0;
  logic               wr_en;
  logic [X_W+Y_W-1:0] wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               busy;
  logic               done;

  fb_rect_fill #(.DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .blank     (blank),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int e;
    int addr;
    int data;
  } exp_wr_t;

  exp_wr_t exp_q[$];
  int      exp_done  = -1;
  int      last_done = -1;
  int      log_q[$];
  int      blank_lo  = -10;
  int      blank_hi  = -10;

  function automatic bit blank_at(input int e);
    return (e >= blank_lo) && (e <= blank_hi);
  endfunction

  // Expand a command accepted on edge n into its expected writes.
  task automatic model_cmd(input int n, input int x0, input int y0, input int w,
                           input int h, input int color);
    int we, he, e;
    we = (w < 256 - x0) ? w : 256 - x0;
    he = (h < 16 - y0) ? h : 16 - y0;
    if (we == 0 || he == 0) begin
      exp_done = n;
    end else begin
      e = n;
      for (int yy = 0; yy < he; yy++) begin
        for (int xx = 0; xx < we; xx++) begin
          while (GATE_EN && blank_at(e)) e++;
          exp_q.push_back('{e, (y0 + yy) * 256 + x0 + xx, color});
          e++;
        end
      end
      exp_done = e;
    end
  endtask

  // blank value held across edge cyc+1
  initial forever begin
    @(negedge clock);
    #1;
    blank = blank_at(cyc + 1);
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clock);
    if (cyc > 0 && !reset) begin
      if (wr_en) begin
        log_q.push_back(int'(wr_addr));
        if (exp_q.size() == 0) begin
          check("unexpected_wr_en", wr_en, 1'b0);
        end else begin
          exp_wr_t x;
          x = exp_q.pop_front();
          check("wr_cycle", cyc, x.e);
          check("wr_addr", wr_addr, x.addr);
          check("wr_data", wr_data, x.data);
          check("busy_during_fill", busy, 1'b1);
          check("ready_during_fill", cmd_ready, 1'b0);
        end
      end else if (exp_q.size() > 0 && exp_q[0].e <= cyc) begin
        check("missing_wr_en", wr_en, 1'b1);
        void'(exp_q.pop_front());
      end
      if (done) begin
        last_done = cyc;
        if (exp_done < 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          check("done_cycle", cyc, exp_done);
          check("busy_at_done", busy, 1'b1);
          exp_done = -1;
        end
      end else if (exp_done >= 0 && cyc >= exp_done) begin
        check("missing_done", done, 1'b1);
        exp_done = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called and returning in the negedge+1 / posedge+1 phase; n = accept edge.
  task automatic issue(input int x0, input int y0, input int w, input int h,
                       input int color, input int b_off, input int b_len,
                       output int n);
    int tries = 0;
    while (!cmd_ready && tries < 6000) begin
      @(negedge clock);
      #1;
      tries++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", cmd_ready, 1'b1);
      n = -1;
      return;
    end
    cmd_x0    = X_W'(x0);
    cmd_y0    = Y_W'(y0);
    cmd_w     = (X_W+1)'(w);
    cmd_h     = (Y_W+1)'(h);
    cmd_color = DATA_W'(color);
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    n = cyc;
    cmd_valid = 1'b0;
    if (b_off >= 0) begin
      blank_lo = n + b_off;
      blank_hi = n + b_off + b_len - 1;
    end else begin
      blank_lo = -10;
      blank_hi = -10;
    end
    model_cmd(n, x0, y0, w, h, color);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clock);
      #1;
      k++;
    end while (!(exp_q.size() == 0 && exp_done < 0 && cmd_ready) && k < 6000);
    check("idle_reached", (exp_q.size() == 0 && exp_done < 0 && cmd_ready), 1'b1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n1, n2, cnt;

    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 12'h000);
    check("rst_wr_data", wr_data, 8'h00);
    reset = 1'b0;
    @(negedge clock);
    #1;

    // Full screen, then the 3x2 command issued as early as possible.
    log_q.delete();
    issue(0, 0, 256, 16, 8'h5A, -1, 0, n1);
    issue(10, 2, 3, 2, 8'h11, -1, 0, n2);
    check("full_done_offset", last_done - n1, 4096);
    check("full_next_accept", n2 - n1, 4098);
    check("full_write_count", log_q.size(), 4096);
    check("full_first_addr", log_q[0], 12'h000);
    check("full_last_addr", log_q[4095], 12'hFFF);
    log_q.delete();
    cnt = 0;
    while (!cmd_ready && cnt < 100) begin
      @(negedge clock);
      #1;
      if (!cmd_ready) cnt++;
    end
    wait_idle();
    check("small_ready_low", cnt, 7);
    check("small_count", log_q.size(), 6);
    check("small_a0", log_q[0], 12'h20A);
    check("small_a1", log_q[1], 12'h20B);
    check("small_a2", log_q[2], 12'h20C);
    check("small_a3", log_q[3], 12'h30A);
    check("small_a4", log_q[4], 12'h30B);
    check("small_a5", log_q[5], 12'h30C);

    // Clipping at the bottom-right corner.
    log_q.delete();
    issue(250, 15, 10, 3, 8'hC3, -1, 0, n1);
    wait_idle();
    check("clip_count", log_q.size(), 6);
    check("clip_first", log_q[0], 12'hFFA);
    check("clip_last", log_q[5], 12'hFFF);

    // Zero width, then back-to-back command.
    log_q.delete();
    issue(20, 4, 0, 5, 8'h99, -1, 0, n1);
    issue(5, 0, 1, 1, 8'h42, -1, 0, n2);
    check("zero_done_offset", last_done - n1, 0);
    check("zero_next_accept", n2 - n1, 2);
    wait_idle();
    check("zero_then_one_count", log_q.size(), 1);

    // Reset during the 20th write of a 256x1 fill.
    log_q.delete();
    issue(0, 3, 256, 1, 8'h77, -1, 0, n1);
    repeat (20) @(negedge clock);
    #1;
    reset = 1'b1;
    while (exp_q.size() > 0 && exp_q[$].e > n1 + 19) void'(exp_q.pop_back());
    exp_done = -1;
    @(negedge clock);
    #1;
    check("abort_wr_en", wr_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_done", done, 1'b0);
    check("abort_writes", log_q.size(), 20);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    wait_idle();

    // Blank window of 5 slots after the second write of a 4x1 fill at 0x100.
    log_q.delete();
    issue(0, 1, 4, 1, 8'hE7, 2, 5, n1);
    wait_idle();
    check("blank_count", log_q.size(), 4);
    check("blank_a0", log_q[0], 12'h100);
    check("blank_a3", log_q[3], 12'h103);
    check("blank_done_offset", last_done - n1, GATE_EN ? 9 : 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: cycle %0d, required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
